// File: rtl/ac_ctrl_pkg.sv
// ac_ctrl_pkg: shared types and constants for the AC panel controller.
// Mode states, key bit indices, timer kinds, display codes, BCD helper.
package ac_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SET_SLEEP = 3'd1,
    SET_OFF   = 3'd2,
    RUN       = 3'd3,
    SET_FAN   = 3'd4
  } state_t;

  typedef enum logic {
    KIND_SLEEP = 1'b0,
    KIND_OFF   = 1'b1
  } kind_t;

  localparam int KEY_MODE = 0;
  localparam int KEY_UP   = 1;
  localparam int KEY_DOWN = 2;
  localparam int KEY_CONF = 3;

  localparam logic [3:0] DISP_WARN  = 4'h9;
  localparam logic [3:0] DISP_SLEEP = 4'hB;
  localparam logic [3:0] DISP_OFF   = 4'hC;

  function automatic logic [23:0] to_bcd(
    input int unsigned val
  );
    logic [23:0] r;
    int unsigned v;
    r = '0;
    v = val;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/ac_timer_ctrl_bcd_countdown.sv
// bcd_countdown: DIGITS-wide BCD down counter with load and clear.
// Flags zero and a match against the warning threshold.
module bcd_countdown
  import ac_ctrl_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int WARN_SECS = 30
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                dec,
  output logic [4*DIGITS-1:0] count,
  output logic                zero,
  output logic                warn_eq
);

  localparam logic [23:0] WarnBcd = to_bcd(WARN_SECS);

  logic [4*DIGITS-1:0] cnt_q;
  logic [4*DIGITS-1:0] dec_val;

  // Ripple borrow: a digit steps down only when all lower digits are 0.
  always_comb begin
    logic borrow;
    borrow  = 1'b1;
    dec_val = cnt_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        dec_val[i*4 +: 4] = (cnt_q[i*4 +: 4] == 4'd0)
                          ? 4'd9
                          : cnt_q[i*4 +: 4] - 4'd1;
      end
      borrow = borrow && (cnt_q[i*4 +: 4] == 4'd0);
    end
  end

  // Clear and load take priority over a same-cycle decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec) begin
      cnt_q <= dec_val;
    end
  end

  assign count   = cnt_q;
  assign zero    = (cnt_q == '0);
  assign warn_eq = (cnt_q == WarnBcd[4*DIGITS-1:0]);

endmodule

// File: rtl/ac_timer_ctrl.sv
// ac_timer_ctrl: key-driven mode FSM, 1 s prescaler and BCD countdown.
// Warning beep is built only when AC_WARN_BEEP_EN is defined.
module ac_timer_ctrl
  import ac_ctrl_pkg::*;
#(
  parameter int  TICK_DIV    = 100_000_000,
  parameter int  DIGITS      = 4,
  parameter int  FAN_LEVELS  = 6,
  parameter int  WARN_SECS   = 30,
  parameter int  BEEP_CYCLES = 100_000_000,
  localparam int FW          = $clog2(FAN_LEVELS)
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic [3:0]          key_value,
  output logic [3:0]          disp_mode,
  output logic [4*DIGITS-1:0] disp_bcd,
  output logic [FW-1:0]       fan_level,
  output logic                power_on,
  output logic                expire,
  output logic                beep
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(DIGITS);

  state_t              state;
  state_t              state_n;
  logic [PW-1:0]       pres;
  logic [4*DIGITS-1:0] edit_buf;
  logic [CW-1:0]       cursor;
  logic [FW-1:0]       edit_lvl;
  logic                armed;
  kind_t               kind;
  logic                exp_valid;
  kind_t               exp_kind;
  logic [4*DIGITS-1:0] count;
  logic                cnt_zero;
  logic                warn_eq;
  logic                beep_low;

  logic k_mode, k_conf, k_up, k_down;
  logic in_set, conf_set, load, disarm;
  logic tick, dec, expire_now;

  assign k_mode = key_value[KEY_MODE];
  assign k_conf = key_value[KEY_CONF] & ~k_mode;
  assign k_up   = key_value[KEY_UP] & ~k_mode
                & ~key_value[KEY_CONF];
  assign k_down = key_value[KEY_DOWN] & ~k_mode
                & ~key_value[KEY_CONF]
                & ~key_value[KEY_UP];

  assign in_set     = (state == SET_SLEEP)
                   || (state == SET_OFF);
  assign conf_set   = in_set && k_conf;
  assign load       = conf_set && (|edit_buf);
  assign disarm     = conf_set && !(|edit_buf);
  assign tick       = (pres == PW'(TICK_DIV - 1));
  assign dec        = armed && tick && !cnt_zero;
  assign expire_now = armed && cnt_zero && !conf_set;

  bcd_countdown #(
    .DIGITS    (DIGITS),
    .WARN_SECS (WARN_SECS)
  ) u_cnt (
    .clk      (CLK),
    .rst_n    (RSTn),
    .clr      (disarm),
    .load     (load),
    .load_val (edit_buf),
    .dec      (dec),
    .count    (count),
    .zero     (cnt_zero),
    .warn_eq  (warn_eq)
  );

  // Free-running 1 s prescaler.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pres <= '0;
    end else begin
      pres <= tick ? '0 : pres + 1'b1;
    end
  end

  // Mode state register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Mode key walks the ring of states.
  always_comb begin
    state_n = state;
    if (k_mode) begin
      unique case (state)
        IDLE:      state_n = SET_SLEEP;
        SET_SLEEP: state_n = SET_OFF;
        SET_OFF:   state_n = RUN;
        RUN:       state_n = SET_FAN;
        SET_FAN:   state_n = IDLE;
        default:   state_n = IDLE;
      endcase
    end
  end

  // Edit buffer, cursor and fan edit level follow the active state.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      edit_buf <= '0;
      cursor   <= '0;
      edit_lvl <= '0;
    end else if (k_mode) begin
      if (state_n == SET_SLEEP || state_n == SET_OFF) begin
        edit_buf <= '0;
        cursor   <= '0;
      end
      if (state_n == SET_FAN) begin
        edit_lvl <= fan_level;
      end
    end else if (in_set) begin
      unique case (1'b1)
        k_up: begin
          cursor <= (cursor == CW'(DIGITS - 1))
                  ? '0 : cursor + 1'b1;
        end
        k_down: begin
          edit_buf[cursor*4 +: 4] <=
            (edit_buf[cursor*4 +: 4] == 4'd9)
            ? 4'd0 : edit_buf[cursor*4 +: 4] + 4'd1;
        end
        default: ;
      endcase
    end else if (state == SET_FAN) begin
      unique case (1'b1)
        k_up: begin
          edit_lvl <= (edit_lvl == FW'(FAN_LEVELS - 1))
                    ? '0 : edit_lvl + 1'b1;
        end
        k_down: begin
          edit_lvl <= (edit_lvl == '0)
                    ? FW'(FAN_LEVELS - 1) : edit_lvl - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Arming, expiry effects, power and committed fan level.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      armed     <= 1'b0;
      kind      <= KIND_SLEEP;
      exp_valid <= 1'b0;
      exp_kind  <= KIND_SLEEP;
      expire    <= 1'b0;
      power_on  <= 1'b1;
      fan_level <= '0;
    end else begin
      expire <= expire_now;
      if (load) begin
        armed     <= 1'b1;
        kind      <= (state == SET_SLEEP) ? KIND_SLEEP : KIND_OFF;
        exp_valid <= 1'b0;
        power_on  <= 1'b1;
      end else if (disarm) begin
        armed     <= 1'b0;
        exp_valid <= 1'b0;
      end else if (expire_now) begin
        armed     <= 1'b0;
        exp_valid <= 1'b1;
        exp_kind  <= kind;
        if (kind == KIND_OFF) begin
          power_on <= 1'b0;
        end
      end
      if (state == SET_FAN && k_conf) begin
        fan_level <= edit_lvl;
      end else if (expire_now && kind == KIND_SLEEP
                   && fan_level > FW'(1)) begin
        fan_level <= FW'(1);
      end
    end
  end

`ifdef AC_WARN_BEEP_EN
  localparam int BW = $clog2(BEEP_CYCLES + 1);

  logic          warn_armed;
  logic          beep_q;
  logic [BW-1:0] beep_cnt;
  logic          warn_fire;

  assign warn_fire = armed && warn_armed && warn_eq && !conf_set;

  // One-shot warning per arm; a new load silences a running beep.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      warn_armed <= 1'b0;
      beep_q     <= 1'b1;
      beep_cnt   <= '0;
    end else if (load) begin
      warn_armed <= 1'b1;
      beep_q     <= 1'b1;
      beep_cnt   <= '0;
    end else if (warn_fire) begin
      warn_armed <= 1'b0;
      beep_q     <= 1'b0;
      beep_cnt   <= BW'(BEEP_CYCLES - 1);
    end else if (!beep_q) begin
      if (beep_cnt == '0) begin
        beep_q <= 1'b1;
      end else begin
        beep_cnt <= beep_cnt - 1'b1;
      end
    end
  end

  assign beep     = beep_q;
  assign beep_low = !beep_q;
`else
  localparam int unused_beep = BEEP_CYCLES;
  logic unused_warn;
  assign unused_warn = warn_eq;
  assign beep        = 1'b1;
  assign beep_low    = 1'b0;
`endif

  logic [3:0] lvl4;
  logic [3:0] exp_code;

  assign lvl4     = 4'(edit_lvl);
  assign exp_code = (exp_kind == KIND_OFF) ? DISP_OFF : DISP_SLEEP;

  assign disp_mode = {1'b0, state};

  // Display source selected by the current state.
  always_comb begin
    disp_bcd = '0;
    unique case (state)
      SET_SLEEP, SET_OFF: disp_bcd = edit_buf;
      SET_FAN:            disp_bcd[3:0] = lvl4;
      RUN: begin
        if (beep_low) begin
          disp_bcd = {DIGITS{DISP_WARN}};
        end else if (!armed && exp_valid) begin
          disp_bcd = {DIGITS{exp_code}};
        end else begin
          disp_bcd = count;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ac_timer_ctrl.sv
// tb_ac_timer_ctrl: directed and random stimulus against a
// behavioural model of the AC panel controller.
`timescale 1ns/1ps
module tb_ac_timer_ctrl;

  localparam int TD = 10;
  localparam int DG = 4;
  localparam int FL = 6;
  localparam int WS = 3;
  localparam int BC = 20;
`ifdef AC_WARN_BEEP_EN
  localparam bit BEEP_EN = 1'b1;
`else
  localparam bit BEEP_EN = 1'b0;
`endif

  localparam logic [25:0] RST_VEC =
    {4'd0, 16'd0, 3'd0, 1'b1, 1'b0, 1'b1};

  logic        CLK = 1'b0;
  logic        RSTn = 1'b1;
  logic [3:0]  key_value = '0;
  logic [3:0]  disp_mode;
  logic [15:0] disp_bcd;
  logic [2:0]  fan_level;
  logic        power_on;
  logic        expire;
  logic        beep;
  logic [25:0] obs;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  ac_timer_ctrl #(
    .TICK_DIV    (TD),
    .DIGITS      (DG),
    .FAN_LEVELS  (FL),
    .WARN_SECS   (WS),
    .BEEP_CYCLES (BC)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .key_value (key_value),
    .disp_mode (disp_mode),
    .disp_bcd  (disp_bcd),
    .fan_level (fan_level),
    .power_on  (power_on),
    .expire    (expire),
    .beep      (beep)
  );

  assign obs = {disp_mode, disp_bcd, fan_level,
                power_on, expire, beep};

  // Reference model: integer seconds, digit array, plain arithmetic.
  int m_state, m_cur, m_lvl, m_fan, m_cnt, m_pres, m_left;
  int m_buf[DG];
  bit m_power, m_armed, m_kind, m_expd, m_expkind;
  bit m_expire, m_warn_arm;

  task automatic model_reset();
    m_state = 0; m_cur = 0; m_lvl = 0; m_fan = 0;
    m_cnt = 0; m_pres = 0; m_left = 0;
    for (int i = 0; i < DG; i++) m_buf[i] = 0;
    m_power = 1; m_armed = 0; m_kind = 0; m_expd = 0;
    m_expkind = 0; m_expire = 0; m_warn_arm = 0;
  endtask

  task automatic model_step(input logic [3:0] k);
    int act, val, pw, ost;
    bit tick, setst, conf_set, ldv, exp_now, fire;
    act = k[0] ? 1 : k[3] ? 2 : k[1] ? 3 : k[2] ? 4 : 0;
    tick = (m_pres == TD - 1);
    ost = m_state;
    setst = (ost == 1 || ost == 2);
    val = 0; pw = 1;
    for (int i = 0; i < DG; i++) begin
      val += m_buf[i] * pw;
      pw *= 10;
    end
    conf_set = setst && act == 2;
    ldv = conf_set && val != 0;
    exp_now = m_armed && m_cnt == 0 && !conf_set;
    fire = BEEP_EN && m_armed && m_warn_arm
        && m_cnt == WS && !conf_set;
    m_pres = (m_pres + 1) % TD;
    m_expire = exp_now;
    if (act == 1) begin
      m_state = (m_state + 1) % 5;
      if (m_state == 1 || m_state == 2) begin
        for (int i = 0; i < DG; i++) m_buf[i] = 0;
        m_cur = 0;
      end
      if (m_state == 4) m_lvl = m_fan;
    end else if (setst) begin
      if (act == 3) m_cur = (m_cur + 1) % DG;
      if (act == 4) m_buf[m_cur] = (m_buf[m_cur] + 1) % 10;
    end else if (ost == 4) begin
      if (act == 3) m_lvl = (m_lvl + 1) % FL;
      if (act == 4) m_lvl = (m_lvl + FL - 1) % FL;
    end
    if (ost == 4 && act == 2) m_fan = m_lvl;
    else if (exp_now && !m_kind && m_fan > 1) m_fan = 1;
    if (ldv) begin
      m_armed = 1; m_cnt = val; m_kind = (ost == 2);
      m_expd = 0; m_power = 1;
    end else if (conf_set) begin
      m_armed = 0; m_cnt = 0; m_expd = 0;
    end else if (exp_now) begin
      m_armed = 0; m_expd = 1; m_expkind = m_kind;
      if (m_kind) m_power = 0;
    end else if (m_armed && tick && m_cnt > 0) begin
      m_cnt--;
    end
    if (ldv) begin
      m_warn_arm = 1; m_left = 0;
    end else if (fire) begin
      m_warn_arm = 0; m_left = BC;
    end else if (m_left > 0) begin
      m_left--;
    end
  endtask

  function automatic logic [25:0] exp_vec();
    logic [15:0] b;
    int v;
    b = '0;
    v = m_cnt;
    case (m_state)
      1, 2: for (int i = 0; i < DG; i++) b[i*4 +: 4] = 4'(m_buf[i]);
      4: b[3:0] = 4'(m_lvl);
      3: begin
        if (m_left > 0) b = 16'h9999;
        else if (!m_armed && m_expd) b = m_expkind ? 16'hCCCC : 16'hBBBB;
        else begin
          for (int i = 0; i < DG; i++) begin
            b[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
          end
        end
      end
      default: ;
    endcase
    return {4'(m_state), b, 3'(m_fan), m_power, m_expire, m_left == 0};
  endfunction

  task automatic cycle(input logic [3:0] k);
    key_value = k;
    @(posedge CLK);
    model_step(k);
    @(negedge CLK);
    key_value = '0;
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    model_reset();
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  task automatic test_reset();
    #1 RSTn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== RST_VEC) begin
      failures++;
      $display("FAIL reset_async: got %h want %h", obs, RST_VEC);
    end
    @(negedge CLK);
    RSTn = 1'b1;
    checks++;
    if (obs !== RST_VEC) begin
      failures++;
      $display("FAIL reset_release: got %h want %h", obs, RST_VEC);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0000);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL reset_idle: got %h want %h", obs, exp_vec());
      end
    end
  endtask

  task automatic test_mode_cycle();
    for (int i = 1; i <= 5; i++) begin
      cycle(4'b0001);
      checks++;
      if (disp_mode !== 4'(i % 5)) begin
        failures++;
        $display("FAIL mode_seq: got %0d want %0d", disp_mode, i % 5);
      end
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL mode_model: got %h want %h", obs, exp_vec());
      end
    end
  endtask

  task automatic test_off_countdown();
    int n_exp, n_low, after;
    n_exp = 0; n_low = 0; after = 0;
    cycle(4'b0001);
    cycle(4'b0001);
    cycle(4'b0100);
    cycle(4'b0100);
    cycle(4'b0010);
    cycle(4'b0100);
    checks++;
    if (disp_bcd !== 16'h0012) begin
      failures++;
      $display("FAIL off_edit: got %h want 0012", disp_bcd);
    end
    cycle(4'b1000);
    cycle(4'b0001);
    checks++;
    if (obs !== exp_vec()) begin
      failures++;
      $display("FAIL off_run: got %h want %h", obs, exp_vec());
    end
    for (int i = 0; i < 200; i++) begin
      cycle(4'b0000);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL off_count: got %h want %h", obs, exp_vec());
      end
      if (expire) n_exp++;
      if (!beep) n_low++;
      if (n_exp > 0) after++;
      if (after > 5) break;
    end
    checks++;
    if (n_exp !== 1) begin
      failures++;
      $display("FAIL off_expire_count: got %0d want 1", n_exp);
    end
    checks++;
    if (power_on !== 1'b0) begin
      failures++;
      $display("FAIL off_power: got %b want 0", power_on);
    end
    checks++;
    if (disp_bcd !== 16'hCCCC) begin
      failures++;
      $display("FAIL off_disp: got %h want CCCC", disp_bcd);
    end
    checks++;
    if (n_low !== (BEEP_EN ? BC : 0)) begin
      failures++;
      $display("FAIL off_beep_len: got %0d want %0d",
               n_low, BEEP_EN ? BC : 0);
    end
    cycle(4'b0001);
    cycle(4'b0001);
  endtask

  task automatic test_sleep();
    int n_exp, after;
    n_exp = 0; after = 0;
    for (int i = 0; i < 4; i++) cycle(4'b0001);
    for (int i = 0; i < 4; i++) cycle(4'b0010);
    cycle(4'b1000);
    checks++;
    if (fan_level !== 3'd4) begin
      failures++;
      $display("FAIL sleep_fan_set: got %0d want 4", fan_level);
    end
    cycle(4'b0001);
    cycle(4'b0001);
    for (int i = 0; i < 5; i++) cycle(4'b0100);
    cycle(4'b1000);
    cycle(4'b0001);
    cycle(4'b0001);
    for (int i = 0; i < 100; i++) begin
      cycle(4'b0000);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL sleep_count: got %h want %h", obs, exp_vec());
      end
      if (expire) n_exp++;
      if (n_exp > 0) after++;
      if (after > 2) break;
    end
    checks++;
    if (fan_level !== 3'd1 || n_exp !== 1) begin
      failures++;
      $display("FAIL sleep_fan: got %0d/%0d want 1/1", fan_level, n_exp);
    end
    checks++;
    if (disp_bcd !== 16'hBBBB || power_on !== 1'b1) begin
      failures++;
      $display("FAIL sleep_disp: got %h/%b want BBBB/1",
               disp_bcd, power_on);
    end
    cycle(4'b0001);
    cycle(4'b0001);
  endtask

  task automatic test_fan();
    for (int i = 0; i < 4; i++) cycle(4'b0001);
    cycle(4'b0100);
    cycle(4'b1000);
    checks++;
    if (fan_level !== 3'd0) begin
      failures++;
      $display("FAIL fan_zero: got %0d want 0", fan_level);
    end
    cycle(4'b0100);
    checks++;
    if (disp_bcd !== 16'h0005) begin
      failures++;
      $display("FAIL fan_down_wrap: got %h want 0005", disp_bcd);
    end
    cycle(4'b0010);
    checks++;
    if (disp_bcd !== 16'h0000) begin
      failures++;
      $display("FAIL fan_up_wrap: got %h want 0000", disp_bcd);
    end
    cycle(4'b0010);
    checks++;
    if (disp_bcd !== 16'h0001) begin
      failures++;
      $display("FAIL fan_up: got %h want 0001", disp_bcd);
    end
    cycle(4'b1000);
    checks++;
    if (fan_level !== 3'd1) begin
      failures++;
      $display("FAIL fan_commit: got %0d want 1", fan_level);
    end
    cycle(4'b0001);
  endtask

  task automatic test_tick_align();
    bit found;
    found = 0;
    cycle(4'b0001);
    for (int i = 0; i < 7; i++) cycle(4'b0100);
    for (int i = 0; i < 3 * TD; i++) begin
      if (m_pres == TD - 1) begin
        found = 1;
        break;
      end
      cycle(4'b0000);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL tick_wait: got no tick phase want one");
    end
    cycle(4'b1000);
    cycle(4'b0001);
    cycle(4'b0001);
    checks++;
    if (disp_bcd !== 16'h0007) begin
      failures++;
      $display("FAIL tick_load_wins: got %h want 0007", disp_bcd);
    end
    checks++;
    if (obs !== exp_vec()) begin
      failures++;
      $display("FAIL tick_model: got %h want %h", obs, exp_vec());
    end
    cycle(4'b0001);
    cycle(4'b0001);
  endtask

  task automatic test_random();
    logic [3:0] k;
    for (int i = 0; i < 3000; i++) begin
      k = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      cycle(k);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL random: key %b got %h want %h", k, obs, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    int n_exp;
    n_exp = 0;
    do_reset();
    cycle(4'b0001);
    cycle(4'b0001);
    for (int i = 0; i < 5; i++) cycle(4'b0100);
    cycle(4'b1000);
    cycle(4'b0001);
    for (int i = 0; i < 15; i++) cycle(4'b0000);
    #2 RSTn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== RST_VEC) begin
      failures++;
      $display("FAIL reset_mid: got %h want %h", obs, RST_VEC);
    end
    @(negedge CLK);
    RSTn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cycle(4'b0000);
      if (expire) n_exp++;
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL reset_mid_after: got %h want %h", obs, exp_vec());
      end
    end
    checks++;
    if (n_exp !== 0) begin
      failures++;
      $display("FAIL reset_mid_expire: got %0d want 0", n_exp);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_mode_cycle();
    test_off_countdown();
    test_sleep();
    test_fan();
    test_tick_align();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
